// File: rtl/radio_ramp_pkg.sv
// Shared types and constants for the radio PA/LNA ramp controller.
// RADIO_RAMP_WATCHDOG_EN (optional) enables the ON-state watchdog in the top.
package radio_ramp_pkg;

  localparam int          RAMP_CNT_W = 8;
  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAMPUP   = 3'd1,
    ST_RX_ON    = 3'd2,
    ST_TX_ON    = 3'd3,
    ST_RAMPDOWN = 3'd4
  } ramp_state_e;

  function automatic logic is_on_state(input logic [2:0] st);
    return (st == ST_RX_ON) || (st == ST_TX_ON);
  endfunction

endpackage

// File: rtl/radio_ramp_ctrl_if.sv
// Request/status bundle between the timing engine and the ramp controller.
// timeoutErr exists only when RADIO_RAMP_WATCHDOG_EN is defined.
interface radio_ramp_ctrl_if;
  logic       isolate;
  logic       radioEnable1;
  logic       radioEnable2;
  logic       radioRxEn1;
  logic       radioRxEn2;
  logic       lnaEn;
  logic       paEn;
  logic       ready;
  logic       disabled;
  logic       mismatchErr;
  logic [2:0] state;
`ifdef RADIO_RAMP_WATCHDOG_EN
  logic       timeoutErr;
`endif

  modport master (
`ifdef RADIO_RAMP_WATCHDOG_EN
    input  timeoutErr,
`endif
    output isolate, radioEnable1, radioEnable2, radioRxEn1, radioRxEn2,
    input  lnaEn, paEn, ready, disabled, mismatchErr, state
  );

  modport slave (
`ifdef RADIO_RAMP_WATCHDOG_EN
    output timeoutErr,
`endif
    input  isolate, radioEnable1, radioEnable2, radioRxEn1, radioRxEn2,
    output lnaEn, paEn, ready, disabled, mismatchErr, state
  );
endinterface

// File: rtl/radio_ramp_ctrl_counter.sv
// Loadable down-counter shared by the ramp-up and ramp-down phases.
module ramp_counter
  import radio_ramp_pkg::*;
(
  input  logic                  ck,
  input  logic                  arst,
  input  logic                  load,
  input  logic                  dec,
  input  logic [RAMP_CNT_W-1:0] load_value,
  output logic [RAMP_CNT_W-1:0] value,
  output logic                  zero
);

  logic [RAMP_CNT_W-1:0] cnt_r;

  // Count register: load wins over decrement, saturates at zero.
  always_ff @(posedge ck) begin
    if (arst) begin
      cnt_r <= {RAMP_CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_value;
    end else if (dec && (cnt_r != {RAMP_CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(RAMP_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign value = cnt_r;
  assign zero  = (cnt_r == {RAMP_CNT_W{1'b0}});

endmodule

// File: rtl/radio_ramp_ctrl.sv
// PA/LNA enable sequencing with timed ramp-up/ramp-down and redundant-input checking.
// Optional macro RADIO_RAMP_WATCHDOG_EN bounds ON time and adds timeoutErr.
module radio_ramp_ctrl
  import radio_ramp_pkg::*;
#(
  parameter int unsigned RAMPUP_CYCLES   = 40,
  parameter int unsigned RAMPDOWN_CYCLES = 6
) (
  input logic               ck,
  input logic               arst,
  radio_ramp_ctrl_if.slave  rr
);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_RAMPUP   = ST_RAMPUP;
  localparam logic [2:0] S_RX_ON    = ST_RX_ON;
  localparam logic [2:0] S_TX_ON    = ST_TX_ON;
  localparam logic [2:0] S_RAMPDOWN = ST_RAMPDOWN;

  localparam logic [RAMP_CNT_W-1:0] RUP_LOAD = RAMP_CNT_W'(RAMPUP_CYCLES - 1);
  localparam logic [RAMP_CNT_W-1:0] RDN_LOAD = RAMP_CNT_W'(RAMPDOWN_CYCLES - 1);

  logic [2:0]            state_r, nxt_s;
  logic                  dir_r, lna_r, pa_r, ready_r, dis_r, mis_r;
  logic                  req_s, rx_s, mis_now_s, dir_load_s;
  logic                  cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [RAMP_CNT_W-1:0] cnt_val_s, cnt_value_s;

  assign req_s     = (rr.radioEnable1 | rr.radioEnable2) & ~rr.isolate;
  assign rx_s      = (rr.radioRxEn1 | rr.radioRxEn2) & ~rr.isolate;
  assign mis_now_s = ~rr.isolate & ((rr.radioEnable1 ^ rr.radioEnable2) |
                                    (rr.radioRxEn1 ^ rr.radioRxEn2));

  ramp_counter u_cnt (
    .ck         (ck),
    .arst       (arst),
    .load       (cnt_load_s),
    .dec        (cnt_dec_s),
    .load_value (cnt_val_s),
    .value      (cnt_value_s),
    .zero       (cnt_zero_s)
  );

`ifdef RADIO_RAMP_WATCHDOG_EN
  logic [15:0] on_cnt_r;
  logic        to_r, wdog_hit_s;

  assign wdog_hit_s = is_on_state(state_r) && (on_cnt_r == (WDOG_LIMIT - 16'd1));

  // ON-time counter restarts on every entry to RX_ON/TX_ON.
  always_ff @(posedge ck) begin
    if (arst) begin
      on_cnt_r <= 16'd0;
      to_r     <= 1'b0;
    end else begin
      to_r <= to_r | wdog_hit_s;
      if (is_on_state(nxt_s) && !is_on_state(state_r)) begin
        on_cnt_r <= 16'd0;
      end else if (is_on_state(state_r) && (on_cnt_r != WDOG_LIMIT)) begin
        on_cnt_r <= on_cnt_r + 16'd1;
      end else begin
        on_cnt_r <= on_cnt_r;
      end
    end
  end

  assign rr.timeoutErr = to_r;
`endif

  // Next-state and counter-control decode; an aborted ramp-up wins over completion.
  always_comb begin
    nxt_s      = state_r;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_val_s  = {RAMP_CNT_W{1'b0}};
    dir_load_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s) begin
          nxt_s      = S_RAMPUP;
          cnt_load_s = 1'b1;
          cnt_val_s  = RUP_LOAD;
          dir_load_s = 1'b1;
        end else begin
          nxt_s = S_IDLE;
        end
      end
      S_RAMPUP: begin
        if (!req_s) begin
          nxt_s      = S_RAMPDOWN;
          cnt_load_s = 1'b1;
          cnt_val_s  = RDN_LOAD;
        end else if (cnt_zero_s) begin
          nxt_s = dir_r ? S_RX_ON : S_TX_ON;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      S_RX_ON, S_TX_ON: begin
`ifdef RADIO_RAMP_WATCHDOG_EN
        if (wdog_hit_s) begin
          nxt_s      = S_RAMPDOWN;
          cnt_load_s = 1'b1;
          cnt_val_s  = RDN_LOAD;
        end else
`endif
        if (!req_s) begin
          nxt_s      = S_RAMPDOWN;
          cnt_load_s = 1'b1;
          cnt_val_s  = RDN_LOAD;
        end else begin
          nxt_s = state_r;
        end
      end
      S_RAMPDOWN: begin
        if (cnt_zero_s) begin
          nxt_s = S_IDLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        nxt_s = S_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state.
  always_ff @(posedge ck) begin
    if (arst) begin
      state_r <= S_IDLE;
      dir_r   <= 1'b0;
      lna_r   <= 1'b0;
      pa_r    <= 1'b0;
      ready_r <= 1'b0;
      dis_r   <= 1'b0;
      mis_r   <= 1'b0;
    end else begin
      state_r <= nxt_s;
      dir_r   <= dir_load_s ? rx_s : dir_r;
      lna_r   <= (nxt_s == S_RX_ON);
      pa_r    <= (nxt_s == S_TX_ON);
      ready_r <= is_on_state(nxt_s) && !is_on_state(state_r);
      dis_r   <= (state_r == S_RAMPDOWN) && (nxt_s == S_IDLE);
      mis_r   <= mis_r | mis_now_s;
    end
  end

  assign rr.state       = state_r;
  assign rr.lnaEn       = lna_r;
  assign rr.paEn        = pa_r;
  assign rr.ready       = ready_r;
  assign rr.disabled    = dis_r;
  assign rr.mismatchErr = mis_r;

endmodule

// File: tb/tb_radio_ramp_ctrl.sv
// Directed bench for radio_ramp_ctrl: per-cycle scoreboard against a reference model
// plus timing checks taken directly from the required behaviour.
module tb_radio_ramp_ctrl;
  import radio_ramp_pkg::*;

  localparam int RUP = 40;
  localparam int RDN = 6;
`ifdef RADIO_RAMP_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic ck = 1'b0;
  logic arst = 1'b1;
  radio_ramp_ctrl_if rr_if ();

  radio_ramp_ctrl #(.RAMPUP_CYCLES(RUP), .RAMPDOWN_CYCLES(RDN)) dut (
    .ck   (ck),
    .arst (arst),
    .rr   (rr_if.slave)
  );

  always #5 ck = ~ck;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  logic [8:0] sb[$];

  int   m_st = 0;
  int   m_t = 1;
  logic m_dir = 1'b0;
  logic m_mis = 1'b0;
  logic m_to = 1'b0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] observed();
    logic to_o;
`ifdef RADIO_RAMP_WATCHDOG_EN
    to_o = rr_if.timeoutErr;
`else
    to_o = 1'b0;
`endif
    return {rr_if.state, rr_if.lnaEn, rr_if.paEn, rr_if.ready, rr_if.disabled,
            rr_if.mismatchErr, to_o};
  endfunction

  // Reference model: m_t counts cycles spent in the current state, starting at 1.
  function automatic logic [8:0] model_step();
    logic req, rx;
    int   nx;
    logic [2:0] nx3;
    if (arst) begin
      m_st = 0; m_t = 1; m_dir = 1'b0; m_mis = 1'b0; m_to = 1'b0;
      return 9'd0;
    end
    req = (rr_if.radioEnable1 | rr_if.radioEnable2) & ~rr_if.isolate;
    rx  = (rr_if.radioRxEn1 | rr_if.radioRxEn2) & ~rr_if.isolate;
    if (!rr_if.isolate && ((rr_if.radioEnable1 != rr_if.radioEnable2) ||
                           (rr_if.radioRxEn1 != rr_if.radioRxEn2))) m_mis = 1'b1;
    nx = m_st;
    case (m_st)
      0: if (req) begin nx = 1; m_dir = rx; end
      1: if (!req) nx = 4; else if (m_t == RUP) nx = m_dir ? 2 : 3;
      2, 3: if (WD && m_t == 65535) begin nx = 4; m_to = 1'b1; end else if (!req) nx = 4;
      4: if (m_t == RDN) nx = 0;
      default: nx = 0;
    endcase
    nx3 = nx[2:0];
    model_step = {nx3, nx == 2, nx == 3, (nx == 2 || nx == 3) && !(m_st == 2 || m_st == 3),
                  m_st == 4 && nx == 0, m_mis, m_to};
    m_t  = (nx == m_st) ? m_t + 1 : 1;
    m_st = nx;
  endfunction

  task automatic tick();
    logic [8:0] e;
    sb.push_back(model_step());
    @(posedge ck);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check($sformatf("cycle%0d", cyc), {23'd0, observed()}, {23'd0, e});
    end
  endtask

  task automatic set_in(input logic iso, input logic e1, input logic e2,
                        input logic r1, input logic r2);
    rr_if.isolate      = iso;
    rr_if.radioEnable1 = e1;
    rr_if.radioEnable2 = e2;
    rr_if.radioRxEn1   = r1;
    rr_if.radioRxEn2   = r2;
  endtask

  initial begin
    int rup_n, rdy_at, rdy_n, rd_n, dis_n, dis_at, pa_at, on_seen, rup_at, rd_at;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    arst = 1'b1;
    repeat (3) tick();
    check("reset_state", {29'd0, rr_if.state}, 32'd0);
    arst = 1'b0;

    // RX ramp-up
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    rup_n = 0; rdy_at = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rr_if.state == 3'd1) rup_n++;
      if (rr_if.ready) rdy_at = i;
    end
    check("rx_rampup_len", rup_n, RUP);
    check("rx_ready_at", rdy_at, RUP + 1);
    check("rx_lna", {31'd0, rr_if.lnaEn}, 32'd1);
    check("rx_pa", {31'd0, rr_if.paEn}, 32'd0);
    // direction change while ON is ignored
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    check("rx_hold_lna", {31'd0, rr_if.lnaEn}, 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_n = 0; dis_n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rr_if.state == 3'd4) rd_n++;
      if (rr_if.disabled) dis_n++;
    end
    check("rx_rampdown_len", rd_n, RDN);
    check("rx_disabled_n", dis_n, 1);
    check("rx_idle", {29'd0, rr_if.state}, 32'd0);

    // TX cycle
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    pa_at = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (rr_if.paEn && pa_at == 0) pa_at = i;
    end
    check("tx_pa_at", pa_at, RUP + 1);
    check("tx_lna", {31'd0, rr_if.lnaEn}, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_n = 0; dis_n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rr_if.state == 3'd4) rd_n++;
      if (rr_if.disabled) dis_n++;
    end
    check("tx_rampdown_len", rd_n, RDN);
    check("tx_disabled_n", dis_n, 1);
    check("tx_idle", {29'd0, rr_if.state}, 32'd0);

    // Abort during ramp-up
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    rdy_n = 0; on_seen = 0; rd_n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (rr_if.ready) rdy_n++;
      if (rr_if.lnaEn || rr_if.paEn) on_seen++;
      if (rr_if.state == 3'd4) rd_n++;
    end
    check("abort_ready_n", rdy_n, 0);
    check("abort_on_n", on_seen, 0);
    check("abort_rampdown_len", rd_n, RDN);

    // Request held through ramp-down restarts with no gap after IDLE
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (45) tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    dis_at = 0; rup_at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rr_if.disabled) dis_at = i;
      if (rr_if.state == 3'd1 && rup_at == 0) rup_at = i;
    end
    check("b2b_disabled_at", dis_at, RDN);
    check("b2b_rampup_at", rup_at, RDN + 1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    arst = 1'b1;
    tick();
    arst = 1'b0;

    // Mismatch: isolated first (no flag), then live (sticky flag)
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) tick();
    check("iso_no_flag", {31'd0, rr_if.mismatchErr}, 32'd0);
    check("iso_idle", {29'd0, rr_if.state}, 32'd0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("mis_set", {31'd0, rr_if.mismatchErr}, 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    check("mis_sticky", {31'd0, rr_if.mismatchErr}, 32'd1);
    arst = 1'b1;
    tick();
    check("mis_reset", {31'd0, rr_if.mismatchErr}, 32'd0);
    arst = 1'b0;

    // Reset in the middle of ramp-up, then a full ramp again
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (20) tick();
    arst = 1'b1;
    tick();
    check("midreset_outputs", {23'd0, observed()}, 32'd0);
    arst = 1'b0;
    rup_n = 0; rdy_at = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rr_if.state == 3'd1) rup_n++;
      if (rr_if.ready) rdy_at = i;
    end
    check("restart_rampup_len", rup_n, RUP);
    check("restart_ready_at", rdy_at, RUP + 1);

`ifdef RADIO_RAMP_WATCHDOG_EN
    arst = 1'b1;
    tick();
    arst = 1'b0;
    rd_at = 0;
    for (int i = 1; i <= 70000; i++) begin
      tick();
      if (rr_if.state == 3'd4 && rd_at == 0) rd_at = i;
    end
    check("wdog_rampdown_at", rd_at, RUP + 65535 + 1);
    check("wdog_timeout_sticky", {31'd0, rr_if.timeoutErr}, 32'd1);
`else
    rd_at = 0;
    check("no_wdog_rd_at", rd_at + {31'd0, rr_if.ready}, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
